// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Returns {remainder, quotient} after WIDTH iterations plus one correction edge.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] dend_q, dend_d;
    logic [WIDTH-1:0]   dsor_q, dsor_d;
    logic               sgn_q, sgn_d, s1_q, s1_d, s2_q, s2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   abs1, abs2, quo, rem;
    logic [WIDTH:0]     shifted, diff;
    assign abs1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    // remainder stays below the divisor, so its top bit is implicit zero
    assign shifted = dend_q[2*WIDTH-1:WIDTH-1];
    assign diff    = shifted - {1'b0, dsor_q};
    assign quo     = dend_q[WIDTH-1:0];
    assign rem     = dend_q[2*WIDTH-1:WIDTH];
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dend_d   = dend_q;
        dsor_d   = dsor_q;
        sgn_d    = sgn_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                        dend_d  = {{WIDTH{1'b0}}, abs1};
                        dsor_d  = abs2;
                        sgn_d   = signed_div_i;
                        s1_d    = opdata1_i[WIDTH-1];
                        s2_d    = opdata2_i[WIDTH-1];
                    end
                end
            end
            BYZERO: begin
                state_d  = annul_i ? IDLE : END;
                ready_d  = !annul_i;
                result_d = '0;
            end
            ON: begin
                if (annul_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = {(sgn_q && s1_q) ? -rem : rem,
                                (sgn_q && (s1_q ^ s2_q)) ? -quo : quo};
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    dend_d = diff[WIDTH] ? {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0}
                                         : {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dend_q   <= '0;
            dsor_q   <= '0;
            sgn_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dend_q   <= dend_d;
            dsor_q   <= dsor_d;
            sgn_q    <= sgn_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end
    assign result_o = result_q;
    assign ready_o  = ready_q;
endmodule
